// File: rtl/nv_ram_dp_fifo_ctrl_if.sv
// Stream and RAM-pin bundle between the FIFO controller (master) and its
// producers, consumers and the dual-port RAM macro (slave).
interface nv_ram_dp_fifo_ctrl_if #(
   parameter int DW = 64,
   parameter int AW = 8
);
   logic          wr_pvld;
   logic          wr_prdy;
   logic [DW-1:0] wr_pd;
   logic          rd_pvld;
   logic          rd_prdy;
   logic [DW-1:0] rd_pd;
   logic          ram_cena;
   logic [AW-1:0] ram_aa;
   logic [DW-1:0] ram_qa;
   logic          ram_cenb;
   logic [AW-1:0] ram_ab;
   logic [DW-1:0] ram_db;
   logic          ram_stov;
   logic          ram_emasa;
   logic [2:0]    ram_emaa;
   logic [2:0]    ram_emab;
   logic          ram_ret1n;
   logic [AW+1:0] fifo_count;

   modport master (
      input  wr_pvld, wr_pd, rd_prdy, ram_qa,
      output wr_prdy, rd_pvld, rd_pd,
      output ram_cena, ram_aa, ram_cenb, ram_ab, ram_db,
      output ram_stov, ram_emasa, ram_emaa, ram_emab, ram_ret1n, fifo_count
   );

   modport slave (
      output wr_pvld, wr_pd, rd_prdy, ram_qa,
      input  wr_prdy, rd_pvld, rd_pd,
      input  ram_cena, ram_aa, ram_cenb, ram_ab, ram_db,
      input  ram_stov, ram_emasa, ram_emaa, ram_emab, ram_ret1n, fifo_count
   );
endinterface

// File: rtl/nv_ram_dp_fifo_ctrl.sv
// FIFO controller over a 1R/1W RAM macro: write-to-rd_pvld latency 3 cycles, prefetch into a
// 2-entry output buffer; wr_prdy drops when the RAM is full (or on QA capture cycles when guarded).
module nv_ram_dp_fifo_ctrl #(
   parameter int DW       = 64,
   parameter int AW       = 8,
   parameter int DEPTH    = 256,
   parameter bit QA_GUARD = 1'b1
) (
   input logic                   nvdla_core_clk,
   input logic                   nvdla_core_rstn,
   nv_ram_dp_fifo_ctrl_if.master bus
);
   localparam logic [AW:0] RAM_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   ram_cnt;
   logic          rd_inflight;
   logic [1:0]    ob_cnt;
   logic          ob_head;
   logic [DW-1:0] ob_mem [2];

   logic wr_acc;
   logic rd_issue;
   logic rd_pop;
   logic ob_widx;

   assign bus.wr_prdy = (ram_cnt != RAM_FULL) && !(QA_GUARD && rd_inflight);
   // Qualified with reset so the write strobe stays inactive while reset is held.
   assign wr_acc   = bus.wr_pvld && bus.wr_prdy && nvdla_core_rstn;
   assign rd_issue = (ram_cnt != '0) && ((ob_cnt + {1'b0, rd_inflight}) < 2'd2);
   assign rd_pop   = bus.rd_pvld && bus.rd_prdy;
   assign ob_widx  = ob_head ^ ob_cnt[0];

   assign bus.ram_cena = !rd_issue;
   assign bus.ram_aa   = rptr;
   assign bus.ram_cenb = !wr_acc;
   assign bus.ram_ab   = wptr;
   assign bus.ram_db   = wr_acc ? bus.wr_pd : '0;

   assign bus.rd_pvld    = (ob_cnt != 2'd0);
   assign bus.rd_pd      = ob_mem[ob_head];
   assign bus.fifo_count = (AW+2)'(ram_cnt) + (AW+2)'(rd_inflight) + (AW+2)'(ob_cnt);

   assign bus.ram_stov  = 1'b0;
   assign bus.ram_emasa = 1'b0;
   assign bus.ram_emaa  = 3'b010;
   assign bus.ram_emab  = 3'b010;
   assign bus.ram_ret1n = 1'b1;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         wptr        <= '0;
         rptr        <= '0;
         ram_cnt     <= '0;
         rd_inflight <= 1'b0;
         ob_cnt      <= 2'd0;
         ob_head     <= 1'b0;
         ob_mem[0]   <= '0;
         ob_mem[1]   <= '0;
      end else begin
         if (wr_acc)
            wptr <= wptr + 1'b1;
         if (rd_issue)
            rptr <= rptr + 1'b1;
         case ({wr_acc, rd_issue})
            2'b10:   ram_cnt <= ram_cnt + 1'b1;
            2'b01:   ram_cnt <= ram_cnt - 1'b1;
            default: ram_cnt <= ram_cnt;
         endcase
         rd_inflight <= rd_issue;
         // Issue only fires when a slot is guaranteed, so capture never overwrites live data.
         if (rd_inflight)
            ob_mem[ob_widx] <= bus.ram_qa;
         if (rd_pop)
            ob_head <= ~ob_head;
         ob_cnt <= ob_cnt + {1'b0, rd_inflight} - {1'b0, rd_pop};
      end
   end
endmodule

// File: tb/tb_nv_ram_dp_fifo_ctrl.sv
// Directed bench: two controllers (QA_GUARD off/on) each driving a behavioural 256x64 RAM.
module tb_nv_ram_dp_fifo_ctrl;
   logic clk;
   logic rstn;

   nv_ram_dp_fifo_ctrl_if #(.DW(64), .AW(8)) i0 ();
   nv_ram_dp_fifo_ctrl_if #(.DW(64), .AW(8)) i1 ();

   nv_ram_dp_fifo_ctrl #(.DW(64), .AW(8), .DEPTH(256), .QA_GUARD(1'b0)) u_dut0 (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .bus            (i0)
   );
   nv_ram_dp_fifo_ctrl #(.DW(64), .AW(8), .DEPTH(256), .QA_GUARD(1'b1)) u_dut1 (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .bus            (i1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM models; the guarded instance's QA shows port-B data whenever CENB is low.
   logic [63:0] mem0 [256];
   logic [63:0] mem1 [256];
   logic [63:0] qa_r0, qa_r1;
   always @(posedge clk) begin
      if (!i0.ram_cenb) mem0[i0.ram_ab] <= i0.ram_db;
      if (!i0.ram_cena) qa_r0 <= mem0[i0.ram_aa];
      if (!i1.ram_cenb) mem1[i1.ram_ab] <= i1.ram_db;
      if (!i1.ram_cena) qa_r1 <= mem1[i1.ram_aa];
   end
   assign i0.ram_qa = qa_r0;
   assign i1.ram_qa = (!i1.ram_cenb) ? i1.ram_db : qa_r1;

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] q0[$];
   logic [63:0] q1[$];
   logic [7:0]  wa0, ra0, wa1, ra1;
   logic        acc0, acc1, hold0, infl1;
   logic [63:0] held0;
   int          pops0, pops1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input int qsz);
      n_cmp++;
      assert (qsz != 0) else begin
         n_err++;
         $error("FAIL %s: observed pop with %0d words queued, expected at least 1", tag, qsz);
      end
   endtask

   task automatic mon();
      if (!rstn) begin
         wa0 = 8'd0; ra0 = 8'd0; wa1 = 8'd0; ra1 = 8'd0;
         acc0 = 1'b0; acc1 = 1'b0; hold0 = 1'b0; infl1 = 1'b0;
      end else begin
         acc0 = i0.wr_pvld && i0.wr_prdy;
         if (acc0) q0.push_back(i0.wr_pd);
         if (!i0.ram_cenb) begin chk("wr_addr0", 64'(i0.ram_ab), 64'(wa0)); wa0 = wa0 + 8'd1; end
         if (!i0.ram_cena) begin chk("rd_addr0", 64'(i0.ram_aa), 64'(ra0)); ra0 = ra0 + 8'd1; end
         if (hold0 && i0.rd_pvld) chk("rd_hold0", i0.rd_pd, held0);
         if (i0.rd_pvld && i0.rd_prdy) begin
            pop_chk("pop_empty0", q0.size());
            if (q0.size() != 0) chk("rd_data0", i0.rd_pd, q0.pop_front());
            pops0++;
         end
         hold0 = i0.rd_pvld && !i0.rd_prdy;
         held0 = i0.rd_pd;

         acc1 = i1.wr_pvld && i1.wr_prdy;
         if (acc1) q1.push_back(i1.wr_pd);
         if (infl1) chk("qa_guard1", 64'(i1.ram_cenb), 64'd1);
         if (!i1.ram_cenb) begin chk("wr_addr1", 64'(i1.ram_ab), 64'(wa1)); wa1 = wa1 + 8'd1; end
         if (!i1.ram_cena) begin chk("rd_addr1", 64'(i1.ram_aa), 64'(ra1)); ra1 = ra1 + 8'd1; end
         if (i1.rd_pvld && i1.rd_prdy) begin
            pop_chk("pop_empty1", q1.size());
            if (q1.size() != 0) chk("rd_data1", i1.rd_pd, q1.pop_front());
            pops1++;
         end
         infl1 = !i1.ram_cena;
      end
   endtask

   task automatic neg();
      @(negedge clk);
      mon();
   endtask

   task automatic pos();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int base;
      logic [63:0] w;
      pops0 = 0; pops1 = 0;
      rstn = 1'b0;
      i0.wr_pvld = 1'b1; i0.wr_pd = '1; i0.rd_prdy = 1'b1;
      i1.wr_pvld = 1'b0; i1.wr_pd = '0; i1.rd_prdy = 1'b0;

      // Reset values, with a write request held to show the strobe is suppressed
      repeat (3) begin neg(); pos(); end
      neg();
      chk("rst_wr_prdy", 64'(i0.wr_prdy), 64'd1);
      chk("rst_rd_pvld", 64'(i0.rd_pvld), 64'd0);
      chk("rst_rd_pd",   i0.rd_pd, 64'd0);
      chk("rst_cena",    64'(i0.ram_cena), 64'd1);
      chk("rst_cenb",    64'(i0.ram_cenb), 64'd1);
      chk("rst_aa",      64'(i0.ram_aa), 64'd0);
      chk("rst_ab",      64'(i0.ram_ab), 64'd0);
      chk("rst_db",      i0.ram_db, 64'd0);
      chk("rst_count",   64'(i0.fifo_count), 64'd0);
      chk("tie_stov",    64'(i0.ram_stov), 64'd0);
      chk("tie_emasa",   64'(i0.ram_emasa), 64'd0);
      chk("tie_emaa",    64'(i0.ram_emaa), 64'd2);
      chk("tie_emab",    64'(i0.ram_emab), 64'd2);
      chk("tie_ret1n",   64'(i0.ram_ret1n), 64'd1);
      pos();
      i0.wr_pvld = 1'b0; i0.rd_prdy = 1'b0;
      rstn = 1'b1;
      neg(); pos();

      // Single write latency
      w = 64'hDEAD_BEEF_0000_0001;
      i0.wr_pvld = 1'b1; i0.wr_pd = w;
      neg();
      chk("t0_cenb", 64'(i0.ram_cenb), 64'd0);
      chk("t0_ab",   64'(i0.ram_ab), 64'd0);
      chk("t0_db",   i0.ram_db, w);
      chk("t0_cena", 64'(i0.ram_cena), 64'd1);
      pos(); i0.wr_pvld = 1'b0;
      neg();
      chk("t1_cena",  64'(i0.ram_cena), 64'd0);
      chk("t1_aa",    64'(i0.ram_aa), 64'd0);
      chk("t1_count", 64'(i0.fifo_count), 64'd1);
      pos(); neg();
      chk("t2_pvld",  64'(i0.rd_pvld), 64'd0);
      chk("t2_count", 64'(i0.fifo_count), 64'd1);
      pos(); neg();
      chk("t3_pvld",  64'(i0.rd_pvld), 64'd1);
      chk("t3_pd",    i0.rd_pd, w);
      pos(); i0.rd_prdy = 1'b1;
      neg(); pos(); neg();
      chk("t5_pvld",  64'(i0.rd_pvld), 64'd0);
      chk("t5_count", 64'(i0.fifo_count), 64'd0);
      chk("t5_pops",  64'(pops0), 64'd1);
      pos();

      // 300 back-to-back incrementing words, wrapping the RAM address
      base = pops0; n = 0;
      i0.wr_pvld = 1'b1; i0.wr_pd = 64'd1000;
      for (int c = 0; c < 2000 && n < 300; c++) begin
         neg();
         if (acc0) n++;
         pos();
         i0.wr_pd = 64'(1000 + n);
         if (n == 300) i0.wr_pvld = 1'b0;
      end
      for (int c = 0; c < 1000 && q0.size() != 0; c++) begin neg(); pos(); end
      neg();
      chk("stream_sent",  64'(n), 64'd300);
      chk("stream_pops",  64'(pops0 - base), 64'd300);
      chk("stream_count", 64'(i0.fifo_count), 64'd0);
      pos();

      // Fill with reads stalled
      i0.rd_prdy = 1'b0; n = 0;
      i0.wr_pvld = 1'b1; i0.wr_pd = 64'd5000;
      for (int c = 0; c < 400; c++) begin
         neg();
         if (!acc0) break;
         n++;
         pos();
         i0.wr_pd = 64'(5000 + n);
      end
      pos(); i0.wr_pvld = 1'b0;
      neg(); pos(); neg();
      chk("full_accepted", 64'(n), 64'd258);
      chk("full_count",    64'(i0.fifo_count), 64'd258);
      chk("full_wr_prdy",  64'(i0.wr_prdy), 64'd0);
      chk("full_rd_pvld",  64'(i0.rd_pvld), 64'd1);
      chk("full_head",     i0.rd_pd, 64'd5000);
      pos(); i0.rd_prdy = 1'b1;
      neg();
      pos(); i0.rd_prdy = 1'b0;
      neg();
      chk("pop1_wr_prdy", 64'(i0.wr_prdy), 64'd0);
      pos(); neg();
      chk("pop2_wr_prdy", 64'(i0.wr_prdy), 64'd1);
      chk("pop2_count",   64'(i0.fifo_count), 64'd257);
      pos(); i0.rd_prdy = 1'b1;
      for (int c = 0; c < 1000 && q0.size() != 0; c++) begin neg(); pos(); end
      neg();
      chk("full_drained", 64'(q0.size()), 64'd0);
      chk("full_count0",  64'(i0.fifo_count), 64'd0);
      pos();

      // Random payloads with random valid and ready
      n = 0;
      i0.wr_pvld = 1'b0;
      for (int c = 0; c < 20000 && (n < 1000 || q0.size() != 0); c++) begin
         neg();
         if (acc0) n++;
         pos();
         i0.rd_prdy = 1'($urandom_range(0, 1));
         if (acc0 || !i0.wr_pvld) begin
            if (n < 1000 && $urandom_range(0, 3) != 0) begin
               i0.wr_pvld = 1'b1;
               i0.wr_pd = {$urandom, $urandom};
            end else begin
               i0.wr_pvld = 1'b0;
            end
         end
      end
      neg();
      chk("rand_sent",    64'(n), 64'd1000);
      chk("rand_drained", 64'(q0.size()), 64'd0);
      pos();
      i0.wr_pvld = 1'b0; i0.rd_prdy = 1'b1;

      // Guarded instance: continuous write and read
      base = pops1; n = 0;
      i1.rd_prdy = 1'b1; i1.wr_pvld = 1'b1; i1.wr_pd = 64'h7700_0000;
      for (int c = 0; c < 2000 && n < 200; c++) begin
         neg();
         if (acc1) n++;
         pos();
         i1.wr_pd = 64'h7700_0000 + 64'(n);
         if (n == 200) i1.wr_pvld = 1'b0;
      end
      for (int c = 0; c < 500 && q1.size() != 0; c++) begin neg(); pos(); end
      neg();
      chk("guard_sent",  64'(n), 64'd200);
      chk("guard_pops",  64'(pops1 - base), 64'd200);
      chk("guard_count", 64'(i1.fifo_count), 64'd0);
      pos();

      // Asynchronous reset with 10 entries held
      i0.rd_prdy = 1'b0; n = 0;
      i0.wr_pvld = 1'b1; i0.wr_pd = 64'hABCD_0000;
      for (int c = 0; c < 100 && n < 10; c++) begin
         neg();
         if (acc0) n++;
         pos();
         i0.wr_pd = 64'hABCD_0000 + 64'(n);
      end
      i0.wr_pvld = 1'b0;
      neg(); pos(); neg(); pos();
      neg();
      chk("pre_rst_count", 64'(i0.fifo_count), 64'd10);
      i0.wr_pvld = 1'b1; i0.wr_pd = 64'hFFFF_0000_FFFF_0000;
      @(posedge clk); #2;
      rstn = 1'b0;
      #1;
      chk("arst_wr_prdy", 64'(i0.wr_prdy), 64'd1);
      chk("arst_rd_pvld", 64'(i0.rd_pvld), 64'd0);
      chk("arst_rd_pd",   i0.rd_pd, 64'd0);
      chk("arst_cena",    64'(i0.ram_cena), 64'd1);
      chk("arst_cenb",    64'(i0.ram_cenb), 64'd1);
      chk("arst_aa",      64'(i0.ram_aa), 64'd0);
      chk("arst_ab",      64'(i0.ram_ab), 64'd0);
      chk("arst_db",      i0.ram_db, 64'd0);
      chk("arst_count",   64'(i0.fifo_count), 64'd0);
      q0.delete(); q1.delete();
      i0.wr_pvld = 1'b0;
      neg();
      rstn = 1'b1;
      pos();
      base = pops0;
      w = 64'h1234_5678_9ABC_DEF0;
      i0.wr_pvld = 1'b1; i0.wr_pd = w; i0.rd_prdy = 1'b1;
      neg(); pos();
      i0.wr_pvld = 1'b0;
      for (int c = 0; c < 10 && pops0 == base; c++) begin neg(); pos(); end
      neg(); pos(); neg();
      chk("post_rst_pops",  64'(pops0 - base), 64'd1);
      chk("post_rst_pvld",  64'(i0.rd_pvld), 64'd0);
      chk("post_rst_count", 64'(i0.fifo_count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
